dmem_responder: RTL

- Slave end of the core's data-memory bus. It services the core's load and store requests from an internal word RAM and a small UART MMIO window.
- It stalls the core pipeline through mem_hold for a configurable number of wait states.
- It owns the UART TX queue and the RX pop handshake.
- It sits beside the core top and ties directly onto the riscv_bus mem_* signals.

---
 rtl/dmem_responder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory bus slave: word RAM plus a UART MMIO window, with wait-state stalls,
// a TX byte queue and an RX pop handshake.
module dmem_responder #(
    parameter int          RAM_WORDS   = 4096,
    parameter int          WAIT_CYCLES = 2,
    parameter int          TXQ_DEPTH   = 4,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        mem_rea,
    input  logic        mem_wea,
    input  logic [3:0]  mem_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_din,
    output logic [31:0] mem_dout,
    output logic        mem_hold,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        bus_err
);

    localparam int            AW        = $clog2(RAM_WORDS);
    localparam int            PW        = $clog2(TXQ_DEPTH);
    localparam int            CW        = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(TXQ_DEPTH);
    localparam logic [3:0]    WAIT_C    = 4'(WAIT_CYCLES);
    localparam logic [31:0]   RAM_BYTES = 32'(RAM_WORDS * 4);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_p0;
    logic [31:0] din_p0;
    logic [3:0]  en_p0;
    logic        we_p0;

    logic [31:0] ram [RAM_WORDS];
    logic [7:0]  txq [TXQ_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] txq_count;

    logic        req;
    logic [31:0] a_addr;
    logic [31:0] a_din;
    logic [3:0]  a_en;
    logic        a_we;
    logic        a_ram;
    logic        a_mmio;
    logic [1:0]  a_off;
    logic        a_unmapped;
    logic        tx_wr;
    logic        pop;
    logic        push;
    logic        ok;
    logic        commit;
    logic        rx_pop;
    logic        txq_full;
    logic        txq_empty;
    logic [31:0] rdata;

    assign req       = (mem_rea | mem_wea) && (mem_en != 4'b0);
    assign txq_full  = (txq_count == DEPTH_C);
    assign txq_empty = (txq_count == '0);
    assign tx_valid  = !txq_empty;
    assign tx_data   = txq[rd_ptr];
    assign pop       = tx_valid & tx_ready;

    // In IDLE the live bus is the access (only reachable with zero wait states);
    // afterwards the latched copy drives decode and commit.
    always_comb begin
        a_addr = addr_p0;
        a_din  = din_p0;
        a_en   = en_p0;
        a_we   = we_p0;
        if (state == IDLE) begin
            a_addr = mem_addr;
            a_din  = mem_din;
            a_en   = mem_en;
            a_we   = mem_wea;
        end
    end

    assign a_ram      = (a_addr < RAM_BYTES);
    assign a_mmio     = !a_ram && (a_addr[31:4] == MMIO_BASE[31:4]);
    assign a_off      = a_addr[3:2];
    assign a_unmapped = !a_ram && !(a_mmio && (a_off != 2'd3));
    assign tx_wr      = a_mmio && (a_off == 2'd0) && a_we;
    assign ok         = !tx_wr || !txq_full || pop;
    assign commit     = !Rst && ok &&
                        (((state == IDLE) && req && (WAIT_C == 4'd0)) ||
                         ((state == WAIT) && (cnt == 4'd1)));
    assign push       = commit && tx_wr;
    assign rx_pop     = a_mmio && (a_off == 2'd2) && !a_we && rx_valid;
    assign mem_hold   = !Rst && (((state == IDLE) && req) || (state == WAIT));

    always_comb begin
        rdata = '0;
        if (a_ram) begin
            rdata = ram[a_addr[AW+1:2]];
        end else if (a_mmio) begin
            case (a_off)
                2'd1:    rdata = {28'b0, bus_err, rx_valid, txq_empty, txq_full};
                2'd2:    rdata = rx_valid ? {24'b0, rx_data} : 32'b0;
                default: rdata = '0;
            endcase
        end
    end

    // Request capture (data only, no reset)
    always_ff @(posedge clk) begin
        if ((state == IDLE) && req) begin
            addr_p0 <= mem_addr;
            din_p0  <= mem_din;
            en_p0   <= mem_en;
            we_p0   <= mem_wea;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mem_dout <= '0;
            rx_ready <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            rx_ready <= commit && rx_pop;
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= commit ? DONE : WAIT;
                        cnt   <= (WAIT_C == 4'd0) ? 4'd1 : WAIT_C;
                    end
                end
                WAIT: begin
                    if (commit)
                        state <= DONE;
                    else if (cnt > 4'd1)
                        cnt <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
            if (commit) begin
                if (!a_we)
                    mem_dout <= rdata;
                if (a_unmapped)
                    bus_err <= 1'b1;
                else if (a_mmio && (a_off == 2'd1) && a_we && a_din[3])
                    bus_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && a_ram && a_we) begin
            for (int i = 0; i < 4; i++) begin
                if (a_en[i])
                    ram[a_addr[AW+1:2]][8*i +: 8] <= a_din[8*i +: 8];
            end
        end
    end

    // TX queue: pop runs freely, push only at commit
    always_ff @(posedge clk) begin
        if (Rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            txq_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   txq_count <= txq_count + 1'b1;
                2'b01:   txq_count <= txq_count - 1'b1;
                default: txq_count <= txq_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            txq[wr_ptr] <= a_din[7:0];
    end

endmodule
